music_sequencer: RTL and testbench

//  Plays a song stored in the 256-entry note ROM on a piezo speaker.
//  - Steps the ROM address at a fixed tempo and latches each returned note code.
//  - Turns the note code into a square wave on the speaker pin.
//  - Sits directly upstream of the ROM (drives address, consumes note) and drives the board buzzer.

---
 rtl/music_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_music_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/music_sequencer.sv
// music_sequencer: steps a note ROM at a fixed tempo and turns each note code into a square wave.
// Optional macro ARTICULATION_GAP_EN mutes the last GAP_TICKS cycles of every step.
module music_sequencer #(
  parameter int unsigned SONG_LEN       = 242,
  parameter int unsigned TICKS_PER_STEP = 12500000,
  parameter int unsigned DIV_SHIFT      = 0,
  parameter int unsigned GAP_TICKS      = 1250000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       loop,
  output logic [7:0] address,
  input  logic [7:0] note,
  output logic       busy,
  output logic       step_pulse,
  output logic       done,
  output logic       speaker
);

  localparam logic [7:0]  LastAddr = 8'(SONG_LEN - 1);
  localparam logic [31:0] LastTick = 32'(TICKS_PER_STEP - 1);
  // Play-counter value on whose edge the muted tail begins.
  localparam logic [31:0] GapStart = 32'(TICKS_PER_STEP - GAP_TICKS - 1);
`ifdef ARTICULATION_GAP_EN
  localparam bit GapEn = 1'b1;
`else
  localparam bit GapEn = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StFetch, StPlay} state_e;

  state_e      state_q;
  logic        fetch_cnt_q;
  logic [31:0] play_cnt_q;
  logic [19:0] div_cnt_q;
  logic [7:0]  cur_note_q;
  logic [7:0]  address_q;
  logic        busy_q;
  logic        step_pulse_q;
  logic        done_q;
  logic        speaker_q;

  logic [7:0]  note_idx;
  logic [7:0]  semi;
  logic [1:0]  oct;
  logic [19:0] base;
  logic [19:0] hp_raw;
  logic [19:0] hp_last;
  logic        is_rest;
  logic        gap_next;

  // Note code -> half-period length in clk cycles.
  always_comb begin
    note_idx = cur_note_q - 8'd1;
    is_rest  = (cur_note_q == 8'd0) || (cur_note_q > 8'd48);
    if (note_idx < 8'd12) begin
      oct  = 2'd0;
      semi = note_idx;
    end else if (note_idx < 8'd24) begin
      oct  = 2'd1;
      semi = note_idx - 8'd12;
    end else if (note_idx < 8'd36) begin
      oct  = 2'd2;
      semi = note_idx - 8'd24;
    end else begin
      oct  = 2'd3;
      semi = note_idx - 8'd36;
    end
    case (semi)
      8'd0:    base = 20'd382234;
      8'd1:    base = 20'd360776;
      8'd2:    base = 20'd340530;
      8'd3:    base = 20'd321419;
      8'd4:    base = 20'd303380;
      8'd5:    base = 20'd286352;
      8'd6:    base = 20'd270270;
      8'd7:    base = 20'd255102;
      8'd8:    base = 20'd240790;
      8'd9:    base = 20'd227273;
      8'd10:   base = 20'd214519;
      8'd11:   base = 20'd202478;
      default: base = 20'd382234;
    endcase
    hp_raw  = base >> (32'(oct) + DIV_SHIFT);
    hp_last = (hp_raw == 20'd0) ? 20'd0 : hp_raw - 20'd1;
  end

  assign gap_next = GapEn && (play_cnt_q >= GapStart);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      fetch_cnt_q  <= 1'b0;
      play_cnt_q   <= '0;
      div_cnt_q    <= '0;
      cur_note_q   <= '0;
      address_q    <= '0;
      busy_q       <= 1'b0;
      step_pulse_q <= 1'b0;
      done_q       <= 1'b0;
      speaker_q    <= 1'b0;
    end else if (stop) begin
      state_q      <= StIdle;
      fetch_cnt_q  <= 1'b0;
      play_cnt_q   <= '0;
      div_cnt_q    <= '0;
      address_q    <= '0;
      busy_q       <= 1'b0;
      step_pulse_q <= 1'b0;
      done_q       <= 1'b0;
      speaker_q    <= 1'b0;
    end else begin
      step_pulse_q <= 1'b0;
      done_q       <= 1'b0;
      case (state_q)
        StIdle: begin
          speaker_q <= 1'b0;
          if (start) begin
            address_q   <= '0;
            fetch_cnt_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= StFetch;
          end
        end
        StFetch: begin
          speaker_q <= 1'b0;
          // Second FETCH cycle: ROM data for the current address is now valid.
          if (fetch_cnt_q) begin
            cur_note_q   <= note;
            div_cnt_q    <= '0;
            play_cnt_q   <= '0;
            step_pulse_q <= 1'b1;
            state_q      <= StPlay;
          end else begin
            fetch_cnt_q <= 1'b1;
          end
        end
        StPlay: begin
          if (play_cnt_q == LastTick) begin
            speaker_q   <= 1'b0;
            div_cnt_q   <= '0;
            fetch_cnt_q <= 1'b0;
            if (address_q < LastAddr) begin
              address_q <= address_q + 8'd1;
              state_q   <= StFetch;
            end else if (loop) begin
              address_q <= '0;
              state_q   <= StFetch;
            end else begin
              address_q <= '0;
              done_q    <= 1'b1;
              busy_q    <= 1'b0;
              state_q   <= StIdle;
            end
          end else begin
            play_cnt_q <= play_cnt_q + 32'd1;
            if (is_rest || gap_next) begin
              div_cnt_q <= '0;
              speaker_q <= 1'b0;
            end else if (div_cnt_q == hp_last) begin
              div_cnt_q <= '0;
              speaker_q <= ~speaker_q;
            end else begin
              div_cnt_q <= div_cnt_q + 20'd1;
            end
          end
        end
        default: begin
          state_q   <= StIdle;
          busy_q    <= 1'b0;
          speaker_q <= 1'b0;
        end
      endcase
    end
  end

  assign address    = address_q;
  assign busy       = busy_q;
  assign step_pulse = step_pulse_q;
  assign done       = done_q;
  assign speaker    = speaker_q;

endmodule

// File: tb/tb_music_sequencer.sv
// Directed bench for music_sequencer: a per-cycle vector table for one full song,
// then hand-written loop-wrap, stop-during-play and reset-during-play sequences.
module tb_music_sequencer;

`ifdef ARTICULATION_GAP_EN
  localparam bit Gap = 1'b1;
`else
  localparam bit Gap = 1'b0;
`endif
  // Speaker level expected once note 25 has toggled; the muted tail hides it with the gap.
  localparam bit S = !Gap;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic       loop;
  logic [7:0] address;
  logic [7:0] note;
  logic       busy;
  logic       step_pulse;
  logic       done;
  logic       speaker;

  int checks = 0;
  int errors = 0;

  music_sequencer #(
    .SONG_LEN      (4),
    .TICKS_PER_STEP(8),
    .DIV_SHIFT     (14),
    .GAP_TICKS     (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .loop      (loop),
    .address   (address),
    .note      (note),
    .busy      (busy),
    .step_pulse(step_pulse),
    .done      (done),
    .speaker   (speaker)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Song ROM with one cycle of read latency.
  always_ff @(posedge clk) begin
    case (address)
      8'd0:    note <= 8'd25;
      8'd1:    note <= 8'd25;
      8'd2:    note <= 8'd0;
      8'd3:    note <= 8'd13;
      default: note <= 8'd0;
    endcase
  end

  typedef struct packed {
    logic       start;
    logic       stop;
    logic       loop;
    logic [7:0] addr;
    logic       busy;
    logic       sp;
    logic       done;
    logic       spk;
  } vec_t;

  localparam int NumVec = 42;
  vec_t tbl [NumVec];

  function automatic vec_t mk(bit st, bit sto, bit lp, int a, bit b, bit p, bit d, bit s);
    vec_t v;
    v.start = st;
    v.stop  = sto;
    v.loop  = lp;
    v.addr  = 8'(a);
    v.busy  = b;
    v.sp    = p;
    v.done  = d;
    v.spk   = s;
    return v;
  endfunction

  task automatic fill(input int lo, input int hi, input vec_t v);
    for (int i = lo; i <= hi; i++) tbl[i] = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [11:0] got;
    logic [11:0] exp;
    bit          done_seen;

    // Row i: inputs applied before edge Ei, outputs expected just after it.
    tbl[0] = mk(1, 0, 0, 0, 1, 0, 0, 0);
    tbl[1] = mk(0, 0, 0, 0, 1, 0, 0, 0);
    tbl[2] = mk(0, 0, 0, 0, 1, 1, 0, 0);
    fill(3, 6, mk(0, 0, 0, 0, 1, 0, 0, 0));
    tbl[5] = mk(1, 0, 0, 0, 1, 0, 0, 0);
    fill(7, 9, mk(0, 0, 0, 0, 1, 0, 0, S));
    fill(10, 11, mk(0, 0, 0, 1, 1, 0, 0, 0));
    tbl[12] = mk(0, 0, 0, 1, 1, 1, 0, 0);
    fill(13, 16, mk(0, 0, 0, 1, 1, 0, 0, 0));
    fill(17, 19, mk(0, 0, 0, 1, 1, 0, 0, S));
    fill(20, 21, mk(0, 0, 0, 2, 1, 0, 0, 0));
    tbl[22] = mk(0, 0, 0, 2, 1, 1, 0, 0);
    fill(23, 29, mk(0, 0, 0, 2, 1, 0, 0, 0));
    fill(30, 31, mk(0, 0, 0, 3, 1, 0, 0, 0));
    tbl[32] = mk(0, 0, 0, 3, 1, 1, 0, 0);
    fill(33, 39, mk(0, 0, 0, 3, 1, 0, 0, 0));
    tbl[40] = mk(0, 0, 0, 0, 0, 0, 1, 0);
    tbl[41] = mk(0, 0, 0, 0, 0, 0, 0, 0);

    rst_n = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    loop  = 1'b0;
    tick();
    tick();
    check("reset_address", 32'(address), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_step_pulse", 32'(step_pulse), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_speaker", 32'(speaker), 32'd0);
    rst_n = 1'b1;

    // Full non-looping song, cycle by cycle.
    for (int i = 0; i < NumVec; i++) begin
      start = tbl[i].start;
      stop  = tbl[i].stop;
      loop  = tbl[i].loop;
      tick();
      got = {address, busy, step_pulse, done, speaker};
      exp = {tbl[i].addr, tbl[i].busy, tbl[i].sp, tbl[i].done, tbl[i].spk};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL vec%0d: got addr=%0d busy=%0b step=%0b done=%0b spk=%0b, expected addr=%0d busy=%0b step=%0b done=%0b spk=%0b",
                 i, got[11:4], got[3], got[2], got[1], got[0],
                 exp[11:4], exp[3], exp[2], exp[1], exp[0]);
      end
    end

    // Looping song: wraps 3->0 without a done pulse.
    loop  = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    done_seen = 1'b0;
    for (int i = 1; i < 40; i++) begin
      tick();
      if (done) done_seen = 1'b1;
    end
    check("loop_last_address", 32'(address), 32'd3);
    tick();
    if (done) done_seen = 1'b1;
    check("loop_wrap_address", 32'(address), 32'd0);
    check("loop_wrap_busy", 32'(busy), 32'd1);
    check("loop_no_done", 32'(done_seen), 32'd0);
    tick();
    tick();
    check("loop_restep_pulse", 32'(step_pulse), 32'd1);
    for (int i = 0; i < 6; i++) tick();
    check("loop_speaker_high", 32'(speaker), 32'(S));

    // Stop and start together mid-PLAY: stop wins.
    stop  = 1'b1;
    start = 1'b1;
    tick();
    check("stop_busy", 32'(busy), 32'd0);
    check("stop_address", 32'(address), 32'd0);
    check("stop_speaker", 32'(speaker), 32'd0);
    check("stop_done", 32'(done), 32'd0);
    check("stop_step_pulse", 32'(step_pulse), 32'd0);
    start = 1'b0;
    tick();
    check("stop_held_busy", 32'(busy), 32'd0);
    stop = 1'b0;
    loop = 1'b0;
    tick();
    tick();
    check("idle_after_stop_busy", 32'(busy), 32'd0);
    check("idle_after_stop_done", 32'(done), 32'd0);

    // Reset during the second FETCH takes effect at the next edge.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i < 12; i++) tick();
    check("pre_reset_address", 32'(address), 32'd1);
    check("pre_reset_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick();
    check("mid_reset_address", 32'(address), 32'd0);
    check("mid_reset_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick();
    check("post_reset_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
